// File: rtl/instr_prefetch_queue_if.sv
// Handshake bundle for the instruction prefetch queue.
// The master modport is the prefetch queue: it drives the memory request and
// the instruction stream. The slave modport is its surroundings: the
// instruction memory, the IF/ID consumer and the branch unit.
interface instr_prefetch_queue_if;
    logic        start_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    modport master (
        input  start_i, mem_ack_i, mem_data_i, instr_ready_i, redirect_i, redirect_pc_i,
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

    modport slave (
        output start_i, mem_ack_i, mem_data_i, instr_ready_i, redirect_i, redirect_pc_i,
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetch over a req/ack handshake
// into a small FIFO of {pc, instr}, drained by IF/ID through valid/ready.
// A redirect flushes the FIFO and retargets fetch; a response that was already
// in flight when the redirect arrived is discarded.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding
// REQ   | request outstanding, response will be pushed
// DROP  | request outstanding, response will be discarded (stale)
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    instr_prefetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];
    logic [31:0]   r_instr;
    logic [31:0]   r_instr_pc;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_after_pop;
    logic [CW-1:0] w_count_next;
    logic          w_room;
    logic [AW-1:0] w_rd_next;
    logic [31:0]   w_pc_inc;

    // A redirect voids any pop or push of its own cycle.
    assign w_pop             = (r_count != '0) & bus.instr_ready_i & ~bus.redirect_i;
    assign w_push            = (r_state == REQ) & bus.mem_ack_i & ~bus.redirect_i;
    assign w_count_after_pop = r_count - CW'(w_pop);
    assign w_count_next      = bus.redirect_i ? '0 : (w_count_after_pop + CW'(w_push));
    // A new request is only launched when its response is guaranteed a slot,
    // so an ack can always be accepted without back-pressure to memory.
    assign w_room            = bus.start_i & (w_count_next < DEPTH_C);
    assign w_rd_next         = r_rd_ptr + AW'(w_pop);
    assign w_pc_inc          = r_fetch_pc + 32'd4;

    // Fetch FSM: owns fetch PC and the registered request/address outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.redirect_i) begin
                        r_fetch_pc <= bus.redirect_pc_i;
                    end
                    // Redirect from IDLE issues straight to the new target next cycle.
                    if (w_room) begin
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= bus.redirect_i ? bus.redirect_pc_i : r_fetch_pc;
                    end
                end
                REQ: begin
                    if (bus.redirect_i) begin
                        r_fetch_pc <= bus.redirect_pc_i;
                        if (bus.mem_ack_i) begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_state <= DROP;
                        end
                    end else if (bus.mem_ack_i) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_room) begin
                            r_mem_addr <= w_pc_inc;
                        end else begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (bus.redirect_i) begin
                        r_fetch_pc <= bus.redirect_pc_i;
                    end
                    if (bus.mem_ack_i) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO occupancy and pointers; a redirect empties the queue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.redirect_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= w_count_next;
            r_rd_ptr <= w_rd_next;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
        end
    end

    // FIFO storage; contents are only meaningful under r_count, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_mem_addr;
            r_data_mem[r_wr_ptr] <= bus.mem_data_i;
        end
    end

    // Head register: loads next cycle's head entry; holds when the queue goes empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
        end else if (w_count_next != '0) begin
            if (w_count_after_pop == '0) begin
                r_instr    <= bus.mem_data_i;
                r_instr_pc <= r_mem_addr;
            end else begin
                r_instr    <= r_data_mem[w_rd_next];
                r_instr_pc <= r_pc_mem[w_rd_next];
            end
        end
    end

    assign bus.mem_req_o     = r_mem_req;
    assign bus.mem_addr_o    = r_mem_addr;
    assign bus.instr_valid_o = (r_count != '0);
    assign bus.instr_o       = r_instr;
    assign bus.instr_pc_o    = r_instr_pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a latency-programmable memory
// responder and a scoreboard of expected {pc, data} entries.
module tb_instr_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    instr_prefetch_queue_if ifc();

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.master)
    );

    // Memory model: acks 'lat' cycles after the request rises.
    int lat = 0;
    int lat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lat_cnt <= 0;
        else if (!ifc.mem_req_o || ifc.mem_ack_i) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    assign ifc.mem_ack_i  = ifc.mem_req_o && (lat_cnt == lat);
    assign ifc.mem_data_i = ifc.mem_addr_o ^ 32'hA5A5_0000;

    int          checks = 0;
    int          failures = 0;
    ent_t        bq[$];
    logic [31:0] exp_pc;
    bit          stale;
    bit          prev_req;
    bit          prev_ack;
    logic [31:0] prev_addr;
    int          req_count;
    int          pop_count;
    logic [31:0] first_pop_pc;
    logic [31:0] last_pop_pc;
    int          n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic sb_reset();
        bq.delete();
        exp_pc   = RESET_PC;
        stale    = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
    endtask

    // One clock: sample and score at the falling edge, return just after the rising edge.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        if (rst) begin
            sb_reset();
        end else begin
            chk("valid", 32'(ifc.instr_valid_o), 32'(bq.size() != 0));
            chk("no_overflow", 32'(bq.size() <= DEPTH), 32'd1);
            if (bq.size() != 0) begin
                chk("head_pc", ifc.instr_pc_o, bq[0].pc);
                chk("head_data", ifc.instr_o, bq[0].data);
            end
            if (prev_req && !prev_ack) begin
                chk("req_hold", 32'(ifc.mem_req_o), 32'd1);
                chk("addr_hold", ifc.mem_addr_o, prev_addr);
            end
            if (ifc.mem_req_o && (!prev_req || prev_ack)) begin
                chk("req_addr", ifc.mem_addr_o, exp_pc);
                req_count++;
            end
            if (ifc.instr_valid_o && ifc.instr_ready_i && !ifc.redirect_i && bq.size() != 0) begin
                if (pop_count == 0) first_pop_pc = ifc.instr_pc_o;
                last_pop_pc = ifc.instr_pc_o;
                e = bq.pop_front();
                pop_count++;
            end
            if (ifc.redirect_i) begin
                bq.delete();
                exp_pc = ifc.redirect_pc_i;
                if (ifc.mem_req_o && !ifc.mem_ack_i) stale = 1'b1;
                else if (ifc.mem_ack_i) stale = 1'b0;
            end else if (ifc.mem_ack_i) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    e.pc   = ifc.mem_addr_o;
                    e.data = ifc.mem_addr_o ^ 32'hA5A5_0000;
                    bq.push_back(e);
                    exp_pc = ifc.mem_addr_o + 32'd4;
                end
            end
            prev_req  = ifc.mem_req_o;
            prev_ack  = ifc.mem_ack_i;
            prev_addr = ifc.mem_addr_o;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        ifc.start_i       = 1'b0;
        ifc.instr_ready_i = 1'b0;
        ifc.redirect_i    = 1'b0;
        ifc.redirect_pc_i = 32'h0;
        sb_reset();

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_req", 32'(ifc.mem_req_o), 32'd0);
        chk("rst_addr", ifc.mem_addr_o, 32'h0);
        chk("rst_valid", 32'(ifc.instr_valid_o), 32'd0);
        chk("rst_instr", ifc.instr_o, 32'h0);
        chk("rst_pc", ifc.instr_pc_o, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Sequential fill with consumer stalled
        lat = 2;
        ifc.instr_ready_i = 1'b0;
        ifc.start_i = 1'b1;
        req_count = 0;
        repeat (30) tick();
        chk("fill_reqs", 32'(req_count), 32'd4);
        chk("fill_req_low", 32'(ifc.mem_req_o), 32'd0);
        chk("fill_valid", 32'(ifc.instr_valid_o), 32'd1);
        chk("fill_head_pc", ifc.instr_pc_o, 32'h0);
        chk("fill_head_data", ifc.instr_o, 32'hA5A5_0000);

        // Redirect from IDLE with a full queue
        ifc.redirect_i = 1'b1;
        ifc.redirect_pc_i = 32'h100;
        tick();
        ifc.redirect_i = 1'b0;
        chk("idle_redir_valid", 32'(ifc.instr_valid_o), 32'd0);
        chk("idle_redir_req", 32'(ifc.mem_req_o), 32'd1);
        chk("idle_redir_addr", ifc.mem_addr_o, 32'h100);
        ifc.instr_ready_i = 1'b1;
        pop_count = 0;
        for (int k = 0; k < 20; k++) begin
            if (pop_count > 0) break;
            tick();
        end
        chk("idle_redir_popped", 32'(pop_count > 0), 32'd1);
        chk("idle_redir_first_pc", first_pop_pc, 32'h100);

        // Streaming with same-cycle ack
        ifc.start_i = 1'b0;
        reset_pulse();
        lat = 0;
        ifc.instr_ready_i = 1'b1;
        ifc.start_i = 1'b1;
        pop_count = 0;
        repeat (24) tick();
        chk("stream_rate", 32'(pop_count >= 10), 32'd1);
        chk("stream_first_pc", first_pop_pc, 32'h0);
        chk("stream_last_pc", last_pop_pc, 32'((pop_count - 1) * 4));

        // Redirect while a request is outstanding
        ifc.start_i = 1'b0;
        reset_pulse();
        lat = 3;
        ifc.start_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (ifc.mem_req_o && ifc.mem_addr_o == 32'h8) break;
            tick();
        end
        chk("req8_seen", 32'(ifc.mem_req_o && ifc.mem_addr_o == 32'h8), 32'd1);
        ifc.redirect_i = 1'b1;
        ifc.redirect_pc_i = 32'h40;
        tick();
        ifc.redirect_i = 1'b0;
        pop_count = 0;
        for (int k = 0; k < 10; k++) begin
            if (ifc.mem_ack_i) break;
            tick();
        end
        chk("stale_ack_seen", 32'(ifc.mem_ack_i), 32'd1);
        chk("stale_ack_addr", ifc.mem_addr_o, 32'h8);
        tick();
        n = 0;
        while (!ifc.mem_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("drop_refetch_delay", 32'(n <= 1), 32'd1);
        chk("drop_refetch_addr", ifc.mem_addr_o, 32'h40);
        for (int k = 0; k < 20; k++) begin
            if (pop_count > 0) break;
            tick();
        end
        chk("drop_first_pc", first_pop_pc, 32'h40);

        // Redirect, ack and pop in the same cycle
        ifc.start_i = 1'b0;
        reset_pulse();
        lat = 2;
        ifc.instr_ready_i = 1'b0;
        ifc.start_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (ifc.mem_ack_i && ifc.instr_valid_o) break;
            tick();
        end
        chk("same_setup", 32'(ifc.mem_ack_i && ifc.instr_valid_o), 32'd1);
        ifc.instr_ready_i = 1'b1;
        ifc.redirect_i = 1'b1;
        ifc.redirect_pc_i = 32'h200;
        tick();
        ifc.redirect_i = 1'b0;
        chk("same_valid", 32'(ifc.instr_valid_o), 32'd0);
        n = 0;
        while (!ifc.mem_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("same_refetch_req", 32'(ifc.mem_req_o), 32'd1);
        chk("same_refetch_addr", ifc.mem_addr_o, 32'h200);

        // Fetch PC wrap
        lat = 1;
        ifc.redirect_i = 1'b1;
        ifc.redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        ifc.redirect_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.mem_req_o && ifc.mem_addr_o == 32'hFFFF_FFFC) break;
            tick();
        end
        chk("wrap_top_req", 32'(ifc.mem_req_o && ifc.mem_addr_o == 32'hFFFF_FFFC), 32'd1);
        for (int k = 0; k < 20; k++) begin
            if (ifc.mem_req_o && ifc.mem_addr_o == 32'h0) break;
            tick();
        end
        chk("wrap_zero_req", 32'(ifc.mem_req_o && ifc.mem_addr_o == 32'h0), 32'd1);

        // Reset in the middle of a request
        lat = 3;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (ifc.mem_req_o) break;
            tick();
        end
        chk("midrst_req_before", 32'(ifc.mem_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_req", 32'(ifc.mem_req_o), 32'd0);
        chk("midrst_valid", 32'(ifc.instr_valid_o), 32'd0);
        chk("midrst_addr", ifc.mem_addr_o, 32'h0);
        tick();
        rst = 1'b0;
        n = 0;
        while (!ifc.mem_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("midrst_refetch_req", 32'(ifc.mem_req_o), 32'd1);
        chk("midrst_refetch_addr", ifc.mem_addr_o, RESET_PC);
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
